// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - handshake bundle between the execute stage and mult_seq
//
// Purpose: groups the operand request, kill and result response signals of the
// sequential multiplier so they travel as one port.
// Ports (signals):
//   InValid/InReady      request handshake (master drives InValid)
//   Op[1:0]              00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   SrcA/SrcB[WIDTH]     multiplicand / multiplier
//   Kill                 pipeline flush, aborts any in-flight operation
//   OutValid/OutReady    result handshake (slave drives OutValid)
//   MultResult[WIDTH]    selected product half
// Modports: master = requester/consumer, slave = multiplier.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Kill;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] MultResult;

  modport master (
    output InValid, Op, SrcA, SrcB, Kill, OutReady,
    input  InReady, OutValid, MultResult
  );

  modport slave (
    input  InValid, Op, SrcA, SrcB, Kill, OutReady,
    output InReady, OutValid, MultResult
  );
endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - multi-cycle shift-add multiplier (MUL/MULH/MULHSU/MULHU)
//
// Purpose: multiplies operand magnitudes, BITS_PER_CYCLE multiplier bits per
// clock, into a 2*WIDTH accumulator and applies the product sign at the end.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   io     mult_seq_if.slave: InValid/InReady, Op, SrcA, SrcB, Kill,
//          OutValid/OutReady, MultResult
module mult_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_seq_if.slave io
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   result;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_fix;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               neg;
  logic               out_valid;
  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic               last_step;

  // An operand is negative only when the mode reads it as signed.
  assign a_neg  = io.SrcA[WIDTH-1] & ((io.Op == 2'b01) | (io.Op == 2'b10));
  assign b_neg  = io.SrcB[WIDTH-1] & (io.Op == 2'b01);
  assign accept = (state == IDLE) & io.InValid & ~io.Kill;

  // Chunks 0..STEPS-1 accumulate; the extra edge at cnt==STEPS applies the
  // sign and half select from the settled accumulator, keeping the negate
  // off the accumulate adder path.
  assign last_step = (cnt == CW'(STEPS));

  assign partial = ({{WIDTH{1'b0}}, mag_a} *
                    {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, mplr[BITS_PER_CYCLE-1:0]})
                   << (cnt * BITS_PER_CYCLE);

  assign acc_fix = neg ? -acc : acc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; Kill overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = CALC;
      CALC:    if (last_step)    state_nxt = DONE;
      DONE:    if (io.OutReady)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
    if (io.Kill) state_nxt = IDLE;
  end

  // Output logic
  always_comb begin
    io.InReady    = (state == IDLE);
    io.OutValid   = out_valid;
    io.MultResult = result;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= 2'b00;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (io.Kill) begin
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Two's-complement negate of the most negative value yields
            // 2^(WIDTH-1), which still fits as an unsigned magnitude.
            mag_a <= a_neg ? -io.SrcA : io.SrcA;
            mplr  <= b_neg ? -io.SrcB : io.SrcB;
            neg   <= a_neg ^ b_neg;
            op_q  <= io.Op;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (last_step) begin
            result    <= (op_q == 2'b00) ? acc_fix[WIDTH-1:0]
                                         : acc_fix[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
          end else begin
            acc  <= acc + partial;
            mplr <= mplr >> BITS_PER_CYCLE;
            cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (io.OutReady) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end
endmodule
